// File: rtl/snake_dir_ctrl.sv
// ---------------------------------------------------------------------------
// snake_dir_ctrl
//
// Input-conditioning and timing stage in front of the snake game core.
// Raw active-low direction buttons are synchronised, debounced and turned
// into press events.  Each event becomes a turn request. A request that
// would reverse the committed direction is rejected, and the last accepted
// one is held as the pending direction. A free-running step timer commits
// the pending direction once per game step and emits a single-cycle strobe.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive differing cycles before a stable level flips
//   STEP_CYCLES     : clk cycles per game step
//   INIT_DIR        : direction loaded on reset (0 left, 1 up, 2 right, 3 down)
//
// Ports
//   clk            in   game clock
//   reset          in   asynchronous, active-high; clears all state
//   btn_n[3:0]     in   raw buttons, active-low (0 left, 1 up, 2 right, 3 down)
//   run            in   1 = step timer advances, 0 = timer frozen
//   move_direction out  committed direction, changes only on a step
//   step           out  one-cycle pulse per game step
//   dir_changed    out  one-cycle pulse with step when the direction changed
//   btn_level[3:0] out  debounced button levels, active-high (1 = held)
// ---------------------------------------------------------------------------
module snake_dir_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned STEP_CYCLES     = 8000000,
    parameter int unsigned INIT_DIR        = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_n,
    input  logic       run,
    output logic [1:0] move_direction,
    output logic       step,
    output logic       dir_changed,
    output logic [3:0] btn_level
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned ST_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(STEP_CYCLES - 1);
    localparam logic [1:0]      INIT_D  = 2'(INIT_DIR);

    // Synchroniser, raw (active-low) polarity
    logic [3:0]      sync1_q;
    logic [3:0]      sync2_q;

    // Debounce state; level is stored active-high so it drives btn_level directly
    logic [3:0]      level_q;
    logic [3:0]      level_d;
    logic [DB_W-1:0] db_cnt_q [4];
    logic [DB_W-1:0] db_cnt_d [4];
    logic [3:0]      press_q;
    logic [3:0]      press_d;

    // Request / pending direction
    logic            req_vld;
    logic [1:0]      req_dir;
    logic            req_ok;
    logic [1:0]      pending_q;
    logic [1:0]      pending_d;

    // Step timer and committed outputs
    logic [ST_W-1:0] step_cnt_q;
    logic [ST_W-1:0] step_cnt_d;
    logic [1:0]      dir_q;
    logic [1:0]      dir_d;
    logic            step_q;
    logic            step_d;
    logic            chg_q;
    logic            chg_d;

    // -----------------------------------------------------------------------
    // Debounce next state.  A raw '1' means released (level 0), so the
    // synchronised sample disagrees with the stable level exactly when the
    // raw bit equals the active-high level bit.
    // -----------------------------------------------------------------------
    always_comb begin
        level_d = level_q;
        press_d = '0;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (sync2_q[i] == level_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    level_d[i]  = ~level_q[i];
                    db_cnt_d[i] = '0;
                    // Only the released->pressed transition is an event
                    press_d[i]  = ~level_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end else begin
                db_cnt_d[i] = '0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Request selection: lowest bit wins (left > up > right > down).
    // The reversal check is against the committed direction, so a queued
    // turn can never set up a 180-degree move for the core.
    // -----------------------------------------------------------------------
    always_comb begin
        req_vld = |press_q;
        req_dir = 2'd3;
        if (press_q[0]) begin
            req_dir = 2'd0;
        end else if (press_q[1]) begin
            req_dir = 2'd1;
        end else if (press_q[2]) begin
            req_dir = 2'd2;
        end

        req_ok    = req_vld && (req_dir != (dir_q ^ 2'd2));
        pending_d = req_ok ? req_dir : pending_q;
    end

    // -----------------------------------------------------------------------
    // Step timer.  The commit uses pending_d so a request accepted on the
    // wrap cycle still lands in this step.
    // -----------------------------------------------------------------------
    always_comb begin
        step_cnt_d = step_cnt_q;
        dir_d      = dir_q;
        step_d     = 1'b0;
        chg_d      = 1'b0;
        if (run) begin
            if (step_cnt_q == ST_LAST) begin
                step_cnt_d = '0;
                step_d     = 1'b1;
                dir_d      = pending_d;
                chg_d      = (pending_d != dir_q);
            end else begin
                step_cnt_d = step_cnt_q + ST_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= 4'hF;
            sync2_q    <= 4'hF;
            level_q    <= '0;
            press_q    <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= '0;
            end
            pending_q  <= INIT_D;
            step_cnt_q <= '0;
            dir_q      <= INIT_D;
            step_q     <= 1'b0;
            chg_q      <= 1'b0;
        end else begin
            sync1_q    <= btn_n;
            sync2_q    <= sync1_q;
            level_q    <= level_d;
            press_q    <= press_d;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            pending_q  <= pending_d;
            step_cnt_q <= step_cnt_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
            chg_q      <= chg_d;
        end
    end

    assign move_direction = dir_q;
    assign step           = step_q;
    assign dir_changed    = chg_q;
    assign btn_level      = level_q;

endmodule

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
Input-conditioning and timing stage directly upstream of the snake game core. It synchronises and debounces the four active-low direction buttons and applies the no-reversal rule. It also generates the periodic game-step tick. On each tick it commits one direction, so the core sees a stable move_direction and a single-cycle step strobe instead of raw buttons and a free-running counter.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive cycles a synchronised button level must differ from its stable level before the stable level flips (10 ms at 25 MHz)
STEP_CYCLES, 8000000, clk cycles per game step; step period = STEP_CYCLES
INIT_DIR, 2, direction loaded on reset (0 left, 1 up, 2 right, 3 down)

Ports:
clk  in  1  pixel/game clock from PLL
reset  in  1  asynchronous, active-high; clears all state
btn_n  in  4  raw buttons, active-low; bit0 left, bit1 up, bit2 right, bit3 down
run  in  1  1 = step timer advances; 0 = timer frozen, no steps
move_direction  out  2  committed direction, changes only on step
step  out  1  one-cycle pulse, one per game step
dir_changed  out  1  one-cycle pulse coincident with step when committed direction changed
btn_level  out  4  debounced button levels, active-high (1 = held)

Behaviour:
- Reset (async assert, sync-to-clk deassert is the integrator's job): sync FFs = 1, stable levels = released, debounce counters = 0, step counter = 0, pending = INIT_DIR, move_direction = INIT_DIR, step = 0, dir_changed = 0, btn_level = 0.
- Synchroniser: 2 FF stages per bit, reset value 1 (released).
- Debounce, per bit, independent:
  - If sync level == stable level, counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, stable flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never flips stable.
- Press event: one-cycle internal pulse when a stable level goes released→pressed. Release produces no event.
- Latency, raw press to press event: 2 (sync) + DEBOUNCE_CYCLES cycles.
- Request selection: if several press events fire in the same cycle, priority is left > up > right > down. One request per cycle at most.
- Reversal rule:
  - The request is rejected if request == move_direction ^ 2, i.e. the opposite of the COMMITTED direction, not the pending one.
  - Otherwise the request overwrites pending. Last accepted request before the step wins.
  - Same-as-committed requests are accepted; they are harmless.
- Step timer:
  - With run=1, the counter counts 0..STEP_CYCLES-1.
  - At STEP_CYCLES-1 the counter wraps to 0 and step=1 the next cycle (registered).
  - On that edge move_direction <= pending_next, where pending_next includes any request accepted in the same cycle (bypass).
  - dir_changed=1 with step iff the new move_direction ≠ the old one.
- run=0: counter holds its value; step and dir_changed stay 0. Debounce and pending updates continue. Resuming run continues from the held count, with no restart.
- Reset mid-step: counter and all state return to reset values immediately; no step is emitted on reset exit.
- Two consecutive turns within one step period: only the last accepted request commits. A request that would reverse the committed direction is always dropped, so the core can never receive a 180° turn.
- All outputs are registered; no combinational path from btn_n or run to outputs.

Test Plan (DEBOUNCE_CYCLES=4, STEP_CYCLES=10, INIT_DIR=2):
1. Reset with run=1, no buttons → move_direction=2 throughout; step pulses every 10 cycles; dir_changed stays 0.
2. btn_n[1] low for 3 cycles, then high → no btn_level change, pending stays 2. The same press held for 20 cycles → btn_level[1]=1 exactly 2+4 cycles after the falling edge; the next step commits move_direction=1 with dir_changed=1.
3. Direction right (2), press left (bit0) held → request rejected; next step keeps move_direction=2, dir_changed=0.
4. Direction right: press up, then down within one step period → pending ends at 3; the step commits 3. Then press up → rejected, since 1 is opposite of 3.
5. Left and down pressed in the same cycle while direction is up → left wins; the step commits 0.
6. run=0 at count 6 for 50 cycles → no step. Then run=1 → step after 4 more cycles. Assert reset mid-period → outputs return to reset values within the same cycle; the first step comes 10 cycles after deassert.
